axi_cal_dac_slave: RTL and testbench
====================================

Name: axi_cal_dac_slave

Overview:
AXI4-Lite responder for the calibration DAC: the slave end of the register bus that the PS-side master drives. It holds four 32-bit read/write registers. A write to the DAC_CODE register launches an SPI-style serial frame to the external calibration DAC. It sits inside the AXI_cal_DAC IP between the interconnect and the DAC pins.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers at 0x0/0x4/0x8/0xC.
DAC_BITS, 16, serial frame length in bits, 1..32.

Ports:
ACLK  in  1  bus and core clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
dac_sclk  out  1  serial clock, idles low
dac_sdi  out  1  serial data, MSB first
dac_cs_n  out  1  frame select, active low
dac_busy  out  1  high while a frame is in progress or pending

Behaviour:
- Reset: all regs 0, all READY/VALID 0, RDATA 0, dac_cs_n 1, dac_sclk 0, dac_sdi 0, dac_busy 0. FSM returns to IDLE immediately, including mid-frame. A partial frame is abandoned, never resumed.
- Register map, index ADDR[3:2]: 0 CONFIG (bit0 enable), 1 DAC_CODE (low DAC_BITS bits sent), 2 CLK_DIV (bits[7:0]), 3 SCRATCH. All 32 bits are stored and read back verbatim.
- Write channel: AWREADY and WREADY pulse high together for exactly one cycle when AWVALID & WVALID & !BVALID. The register updates per WSTRB byte on that edge. BVALID rises the next cycle and holds until BREADY. Only one write is outstanding at a time.
- Read channel: ARREADY pulses one cycle when ARVALID & !RVALID. On the next cycle RVALID=1 and RDATA shows the register value as of the handshake edge. Both hold until RREADY.
- Simultaneous read and write to the same register: the read returns the pre-write value. The two channels are fully independent.
- Launch rule: a write handshake to index 1 with any WSTRB bit set and CONFIG.enable=1 issues a start pulse.
  - If FSM is IDLE: the frame loads the new value.
  - If FSM is busy: set pending. The latest DAC_CODE is sent after the current frame ends. Further writes while pending coalesce.
  - With enable=0: no start pulse and no pending.
  - Clearing enable mid-frame: the current frame completes, pending is dropped.
- Half-period H = CLK_DIV[7:0]+1 ACLK cycles. CLK_DIV is sampled at frame start.
- Serializer FSM:
  - IDLE: cs_n=1, sclk=0.
  - SETUP: cs_n=0, sdi=MSB, lasts H cycles.
  - SHIFT: 2*DAC_BITS half-periods; sclk toggles each H; sdi advances on each falling edge. The DAC samples on rising edges.
  - HOLD: cs_n=1, sclk=0, lasts H cycles.
  - After HOLD: go to SETUP if pending, else IDLE.
- dac_busy goes high the cycle after the launching handshake and stays high through HOLD. Total busy per frame = (2*DAC_BITS+2)*H cycles.

Decomposition:
- Package axi_cal_dac_pkg: register index constants (REG_CONFIG=0, REG_DAC_CODE=1, REG_CLK_DIV=2, REG_SCRATCH=3), CONFIG bit positions, BRESP/RRESP OKAY constant, FSM state enum (IDLE, SETUP, SHIFT, HOLD).
- One sub-module, cal_dac_serializer: start/code/div in; sclk/sdi/cs_n/busy out. The top module keeps the AXI logic and the register file.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, RRESP 0, BRESP 0. (CONFIG=1 enables a frame of code 0x2.)
- Write 0xFFFFFFFF to 0xC with WSTRB=4'b0101, prior value 0 -> readback 0x00FF00FF.
- CONFIG=1, CLK_DIV=0, write DAC_CODE=0xA5C3 -> cs_n low 33 cycles, 16 rising sclk edges, sampled sdi sequence 1010010111000011, busy high 34 cycles.
- During frame 0xA5C3, write 0x1234 then 0x00FF -> one further frame carrying 0x00FF, cs_n high for exactly H between frames.
- CONFIG=0, write DAC_CODE=0x5555 -> no sclk edges, busy stays 0, readback 0x5555.
- Assert ARESETN low for 3 cycles at bit 7 of a frame -> cs_n=1, sclk=0, busy=0 immediately, all registers read 0 after reset.

Source files
------------

// File: rtl/axi_cal_dac_pkg.sv
// Shared definitions for the calibration DAC AXI4-Lite slave: register map,
// response codes, serializer states and the byte-strobe merge helper.
package axi_cal_dac_pkg;

  localparam logic [1:0] REG_CONFIG   = 2'd0;
  localparam logic [1:0] REG_DAC_CODE = 2'd1;
  localparam logic [1:0] REG_CLK_DIV  = 2'd2;
  localparam logic [1:0] REG_SCRATCH  = 2'd3;

  localparam int CFG_ENABLE_BIT = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } dac_state_t;

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cal_dac_serializer.sv
// SPI-style frame generator for the calibration DAC: SETUP, 2*DAC_BITS sclk
// half-periods, HOLD, with one pending relaunch that coalesces repeat starts.
module cal_dac_serializer
  import axi_cal_dac_pkg::*;
#(
  parameter int DAC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                enable,
  input  logic [DAC_BITS-1:0] code,
  input  logic [7:0]          div,
  output logic                sclk,
  output logic                sdi,
  output logic                cs_n,
  output logic                busy
);

  localparam int HALF_W = $clog2(2*DAC_BITS + 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2*DAC_BITS - 1);

  dac_state_t          state;
  logic [7:0]          cnt;
  logic [7:0]          div_q;
  logic [HALF_W-1:0]   half_cnt;
  logic [DAC_BITS:0]   sr;
  logic                pending;
  logic                launch;

  // The extra low bit of sr lets the data line fall to 0 once the LSB has gone.
  assign sdi = sr[DAC_BITS];

  assign launch = (state == IDLE && start) ||
                  (state == HOLD && cnt == 8'd0 && (start || (pending && enable)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      half_cnt <= '0;
      sr       <= '0;
      pending  <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
    end else if (launch) begin
      // code reflects a write landing on this same edge, so the newest value goes out
      state   <= SETUP;
      cnt     <= div;
      div_q   <= div;
      sr      <= {code, 1'b0};
      pending <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b0;
      busy    <= 1'b1;
    end else begin
      if (start && state != IDLE) pending <= 1'b1;
      else if (!enable)           pending <= 1'b0;

      case (state)
        IDLE: begin
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state    <= SHIFT;
            sclk     <= 1'b1;
            cnt      <= div_q;
            half_cnt <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (cnt == 8'd0) begin
            cnt <= div_q;
            if (half_cnt == LAST_HALF) begin
              state <= HOLD;
              sclk  <= 1'b0;
              cs_n  <= 1'b1;
            end else begin
              half_cnt <= half_cnt + HALF_W'(1);
              sclk     <= ~sclk;
              if (sclk) sr <= {sr[DAC_BITS-1:0], 1'b0};
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pending <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_cal_dac_slave.sv
// AXI4-Lite slave with four 32-bit registers; writing DAC_CODE while enabled
// launches a serial frame on the calibration DAC pins.
module axi_cal_dac_slave
  import axi_cal_dac_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int DAC_BITS           = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            dac_sclk,
  output logic                            dac_sdi,
  output logic                            dac_cs_n,
  output logic                            dac_busy
);

  logic [31:0] regs [4];
  logic        aw_ready;
  logic        bvalid;
  logic        ar_ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic        wr_hs;
  logic        rd_hs;
  logic [31:0] wr_merged;
  logic [31:0] dac_code_next;
  logic        dac_start;
  logic        unused_bits;

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];
  assign wr_hs  = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = ar_ready & S_AXI_ARVALID;

  assign wr_merged     = apply_strobe(regs[wr_idx], S_AXI_WDATA, S_AXI_WSTRB);
  assign dac_code_next = (wr_hs && wr_idx == REG_DAC_CODE) ? wr_merged : regs[REG_DAC_CODE];
  assign dac_start     = wr_hs && wr_idx == REG_DAC_CODE && (|S_AXI_WSTRB) &&
                         regs[REG_CONFIG][CFG_ENABLE_BIT];

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = aw_ready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         regs[REG_CONFIG][31:1], regs[REG_CLK_DIV][31:8], dac_code_next};

  // Write path: one-cycle ready pulse, then BVALID until accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready <= 1'b0;
      bvalid   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      aw_ready <= ~aw_ready & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid;
      if (wr_hs) begin
        regs[wr_idx] <= wr_merged;
        bvalid       <= 1'b1;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read path captures on the handshake edge, so a same-cycle write is not visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      ar_ready <= ~ar_ready & S_AXI_ARVALID & ~rvalid;
      if (rd_hs) begin
        rvalid <= 1'b1;
        rdata  <= regs[rd_idx];
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  cal_dac_serializer #(
    .DAC_BITS(DAC_BITS)
  ) u_serializer (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .start  (dac_start),
    .enable (regs[REG_CONFIG][CFG_ENABLE_BIT]),
    .code   (dac_code_next[DAC_BITS-1:0]),
    .div    (regs[REG_CLK_DIV][7:0]),
    .sclk   (dac_sclk),
    .sdi    (dac_sdi),
    .cs_n   (dac_cs_n),
    .busy   (dac_busy)
  );

endmodule

// File: tb/tb_axi_cal_dac_slave.sv
// Directed self-checking bench for axi_cal_dac_slave: register access, strobes,
// serial frame timing/content, coalescing, disable and mid-frame reset.
module tb_axi_cal_dac_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        dac_sclk;
  logic        dac_sdi;
  logic        dac_cs_n;
  logic        dac_busy;

  int checks = 0;
  int errors = 0;

  logic        mon_clear = 1'b0;
  int          rises = 0;
  int          cs_low = 0;
  int          busy_cnt = 0;
  int          frames = 0;
  int          high_run = 0;
  int          last_gap = -1;
  logic [31:0] sdi_bits = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs_n = 1'b1;

  always #5 ACLK = ~ACLK;

  axi_cal_dac_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .DAC_BITS(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .dac_sclk(dac_sclk), .dac_sdi(dac_sdi), .dac_cs_n(dac_cs_n), .dac_busy(dac_busy)
  );

  // Pin monitor, sampled 1 time unit after each rising clock edge.
  always begin
    @(posedge ACLK);
    #1;
    if (mon_clear) begin
      rises = 0; cs_low = 0; busy_cnt = 0; frames = 0;
      high_run = 0; last_gap = -1; sdi_bits = '0;
    end else begin
      if (dac_sclk && !prev_sclk) begin
        rises++;
        sdi_bits = {sdi_bits[30:0], dac_sdi};
      end
      if (!dac_cs_n) cs_low++;
      if (dac_busy) busy_cnt++;
      if (prev_cs_n && !dac_cs_n) begin
        if (frames > 0) last_gap = high_run;
        frames++;
        high_run = 0;
      end else if (dac_cs_n) begin
        high_run++;
      end
    end
    prev_sclk = dac_sclk;
    prev_cs_n = dac_cs_n;
  end

  task automatic clear_monitor();
    @(negedge ACLK); mon_clear = 1'b1;
    @(negedge ACLK); mon_clear = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (S_AXI_AWREADY !== 1'b1) begin
      errors++; $display("[TB] FAIL awready_timeout addr=%h got=%b want=1", addr, S_AXI_AWREADY);
    end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (S_AXI_BVALID !== 1'b1) begin
      errors++; $display("[TB] FAIL bvalid_timeout addr=%h got=%b want=1", addr, S_AXI_BVALID);
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("[TB] FAIL arready_timeout addr=%h got=%b want=1", addr, S_AXI_ARREADY);
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (S_AXI_RVALID !== 1'b1) begin
      errors++; $display("[TB] FAIL rvalid_timeout addr=%h got=%b want=1", addr, S_AXI_RVALID);
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (dac_busy && n < limit) begin @(negedge ACLK); n++; end
    checks++;
    if (dac_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_timeout got=%b want=0", dac_busy);
    end
    repeat (3) @(negedge ACLK);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_handshake got=%b want=00000",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
    end
    checks++;
    if (S_AXI_RDATA !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rdata got=%h want=00000000", S_AXI_RDATA);
    end
    checks++;
    if ({dac_cs_n, dac_sclk, dac_sdi, dac_busy} !== 4'b1000) begin
      errors++; $display("[TB] FAIL reset_pins got=%b want=1000", {dac_cs_n, dac_sclk, dac_sdi, dac_busy});
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_dac_code got=%h want=00000000", d);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b0101, r);
    axi_read(4'hC, d, r);
    checks++;
    if (d !== 32'h00FF_00FF) begin
      errors++; $display("[TB] FAIL strobe_readback got=%h want=00ff00ff", d);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] want [4];
    want[0] = 32'h1; want[1] = 32'h2; want[2] = 32'h3; want[3] = 32'h4;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i*4), want[i], 4'hF, r);
      checks++;
      if (r !== 2'b00) begin
        errors++; $display("[TB] FAIL bresp_%0d got=%b want=00", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i*4), d, r);
      checks++;
      if (d !== want[i] || r !== 2'b00) begin
        errors++; $display("[TB] FAIL readback_%0d got=%h/%b want=%h/00", i, d, r, want[i]);
      end
    end
    wait_idle(200);
  endtask

  task automatic test_frame();
    logic [1:0] r;
    axi_write(4'h8, 32'h0, 4'hF, r);
    clear_monitor();
    axi_write(4'h4, 32'h0000_A5C3, 4'hF, r);
    wait_idle(200);
    checks++;
    if (cs_low !== 33) begin errors++; $display("[TB] FAIL frame_cs_low got=%0d want=33", cs_low); end
    checks++;
    if (rises !== 16) begin errors++; $display("[TB] FAIL frame_rises got=%0d want=16", rises); end
    checks++;
    if (sdi_bits[15:0] !== 16'hA5C3) begin
      errors++; $display("[TB] FAIL frame_sdi got=%h want=a5c3", sdi_bits[15:0]);
    end
    checks++;
    if (busy_cnt !== 34) begin errors++; $display("[TB] FAIL frame_busy got=%0d want=34", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    axi_write(4'h8, 32'h2, 4'hF, r);
    clear_monitor();
    axi_write(4'h4, 32'h0000_A5C3, 4'hF, r);
    axi_write(4'h4, 32'h0000_1234, 4'hF, r);
    axi_write(4'h4, 32'h0000_00FF, 4'hF, r);
    wait_idle(600);
    checks++;
    if (frames !== 2) begin errors++; $display("[TB] FAIL b2b_frames got=%0d want=2", frames); end
    checks++;
    if (sdi_bits !== 32'hA5C3_00FF) begin
      errors++; $display("[TB] FAIL b2b_sdi got=%h want=a5c300ff", sdi_bits);
    end
    checks++;
    if (last_gap !== 3) begin errors++; $display("[TB] FAIL b2b_gap got=%0d want=3", last_gap); end
    checks++;
    if (cs_low !== 198) begin errors++; $display("[TB] FAIL b2b_cs_low got=%0d want=198", cs_low); end
    checks++;
    if (busy_cnt !== 204) begin errors++; $display("[TB] FAIL b2b_busy got=%0d want=204", busy_cnt); end
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(4'h0, 32'h0, 4'hF, r);
    clear_monitor();
    axi_write(4'h4, 32'h0000_5555, 4'hF, r);
    repeat (20) @(negedge ACLK);
    checks++;
    if (rises !== 0) begin errors++; $display("[TB] FAIL disabled_rises got=%0d want=0", rises); end
    checks++;
    if (busy_cnt !== 0) begin errors++; $display("[TB] FAIL disabled_busy got=%0d want=0", busy_cnt); end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h5555) begin errors++; $display("[TB] FAIL disabled_readback got=%h want=00005555", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    axi_write(4'h0, 32'h1, 4'hF, r);
    axi_write(4'h8, 32'h0, 4'hF, r);
    clear_monitor();
    axi_write(4'h4, 32'h0000_A5C3, 4'hF, r);
    axi_write(4'h4, 32'h0000_1111, 4'hF, r);
    n = 0;
    while (rises < 8 && n < 200) begin @(negedge ACLK); n++; end
    checks++;
    if (rises !== 8) begin errors++; $display("[TB] FAIL midframe_reach got=%0d want=8", rises); end
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({dac_cs_n, dac_sclk, dac_busy} !== 3'b100) begin
      errors++; $display("[TB] FAIL midframe_pins got=%b want=100", {dac_cs_n, dac_sclk, dac_busy});
    end
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    clear_monitor();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i*4), d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL midframe_reg_%0d got=%h want=00000000", i, d); end
    end
    repeat (60) @(negedge ACLK);
    checks++;
    if (frames !== 0 || rises !== 0) begin
      errors++; $display("[TB] FAIL midframe_resumed frames=%0d rises=%0d want=0/0", frames, rises);
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_regs();
    test_frame();
    test_back_to_back();
    test_disabled();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
